// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and load/store ports.
// Ties go to the port granted less recently, and an access aborts after TIMEOUT wait cycles.
module mem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req_i,
   input  logic [31:0] inst_addr_i,
   output logic        inst_gnt_o,
   output logic        inst_rvalid_o,
   output logic [31:0] inst_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        err_o
);
   typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
   typedef enum logic {GNT_INST, GNT_DATA} port_t;
   state_t     state;
   port_t      last_gnt;
   logic [7:0] wait_cnt;
   logic       pick_data, pick_inst, tmo;
   always_comb begin
      pick_data = data_req_i && (!inst_req_i || last_gnt == GNT_INST);
      pick_inst = inst_req_i && !pick_data;
      tmo       = !mem_ready_i && wait_cnt == 8'(TIMEOUT - 1);
      stall_o   = state != IDLE || (inst_req_i && !inst_rvalid_o) || (data_req_i && !data_rvalid_o);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_gnt      <= GNT_INST;
         wait_cnt      <= '0;
         inst_gnt_o    <= 1'b0;
         inst_rvalid_o <= 1'b0;
         inst_rdata_o  <= '0;
         data_gnt_o    <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         mem_ce_o      <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_wdata_o   <= '0;
         err_o         <= 1'b0;
      end else begin
         inst_gnt_o    <= 1'b0;
         data_gnt_o    <= 1'b0;
         inst_rvalid_o <= 1'b0;
         data_rvalid_o <= 1'b0;
         err_o         <= 1'b0;
         if (state == IDLE) begin
            wait_cnt <= '0;
            if (pick_data) begin
               state       <= DATA;
               last_gnt    <= GNT_DATA;
               data_gnt_o  <= 1'b1;
               mem_ce_o    <= 1'b1;
               mem_we_o    <= data_we_i;
               mem_addr_o  <= data_addr_i;
               mem_wdata_o <= data_wdata_i;
            end else if (pick_inst) begin
               state       <= INST;
               last_gnt    <= GNT_INST;
               inst_gnt_o  <= 1'b1;
               mem_ce_o    <= 1'b1;
               mem_we_o    <= 1'b0;
               mem_addr_o  <= inst_addr_i;
               mem_wdata_o <= '0;
            end
         end else if (mem_ready_i || tmo) begin
            // a ready on the final wait cycle wins over the timeout
            state    <= IDLE;
            mem_ce_o <= 1'b0;
            wait_cnt <= '0;
            err_o    <= !mem_ready_i;
            if (state == INST) begin
               inst_rvalid_o <= 1'b1;
               inst_rdata_o  <= mem_ready_i ? mem_rdata_i : NOP_INST;
            end else begin
               data_rvalid_o <= 1'b1;
               if (!mem_ready_i) data_rdata_o <= '0;
               else if (!mem_we_o) data_rdata_o <= mem_rdata_i;
            end
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latency, store, timeout and reset.
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        inst_req_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b0, mem_ready_i = 1'b0;
   logic [31:0] inst_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, mem_rdata_i = '0;
   logic        inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o;
   logic        mem_ce_o, mem_we_o, stall_o, err_o;
   logic [31:0] inst_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
   int          checks = 0, errors = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
      .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("rst_ce", mem_ce_o, 0);
      check("rst_gnt", {inst_gnt_o, data_gnt_o}, 0);
      check("rst_rvalid", {inst_rvalid_o, data_rvalid_o, err_o}, 0);
      check("rst_rdata", inst_rdata_o | data_rdata_o | mem_addr_o, 0);
      check("rst_stall", stall_o, 0);
      tick(); tick();
      rst = 1'b0;
      tick();
      // ready while idle is ignored
      mem_ready_i = 1'b1; mem_rdata_i = 32'h5555_5555;
      tick();
      check("idle_ready_rvalid", {inst_rvalid_o, data_rvalid_o}, 0);
      check("idle_ready_rdata", inst_rdata_o, 0);
      mem_ready_i = 1'b0;
      // request withdrawn before an edge is lost
      inst_req_i = 1'b1; #2; inst_req_i = 1'b0;
      tick();
      check("withdraw_gnt", inst_gnt_o, 0);
      // single fetch
      inst_req_i = 1'b1; inst_addr_i = 32'h100; #1;
      check("fetch_stall_req", stall_o, 1);
      tick();
      check("fetch_gnt", inst_gnt_o, 1);
      check("fetch_ce", mem_ce_o, 1);
      check("fetch_addr", mem_addr_o, 32'h100);
      check("fetch_we", mem_we_o, 0);
      inst_req_i = 1'b0; inst_addr_i = 32'hFFFF; mem_ready_i = 1'b1; mem_rdata_i = 32'h0050_0093; #1;
      check("fetch_stall_busy", stall_o, 1);
      tick();
      mem_ready_i = 1'b0;
      check("fetch_rvalid", inst_rvalid_o, 1);
      check("fetch_rdata", inst_rdata_o, 32'h0050_0093);
      check("fetch_ce_done", mem_ce_o, 0);
      check("fetch_gnt_done", inst_gnt_o, 0);
      check("fetch_stall_done", stall_o, 0);
      tick();
      check("fetch_rvalid_pulse", inst_rvalid_o, 0);
      // store
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h2000; data_wdata_i = 32'hDEAD_BEEF;
      tick();
      check("st_gnt", data_gnt_o, 1);
      check("st_we", mem_we_o, 1);
      check("st_addr", mem_addr_o, 32'h2000);
      check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      data_req_i = 1'b0; data_addr_i = 32'h0; data_wdata_i = 32'h0; data_we_i = 1'b0;
      tick();
      check("st_hold_gnt", data_gnt_o, 0);
      check("st_hold", {mem_ce_o, mem_we_o}, 2'b11);
      check("st_hold_addr", mem_addr_o, 32'h2000);
      check("st_hold_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      tick();
      mem_ready_i = 1'b0;
      check("st_rvalid", data_rvalid_o, 1);
      check("st_rdata_kept", data_rdata_o, 0);
      check("st_ce_done", mem_ce_o, 0);
      // alternation from reset: data wins the first tie
      rst = 1'b1; tick(); rst = 1'b0;
      inst_req_i = 1'b1; data_req_i = 1'b1; data_addr_i = 32'h40; inst_addr_i = 32'h80;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("alt_gnt", {data_gnt_o, inst_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
         mem_ready_i = 1'b1; mem_rdata_i = 32'hA0 + i;
         tick();
         mem_ready_i = 1'b0;
         check("alt_no_gnt_in_rvalid", {data_gnt_o, inst_gnt_o}, 0);
         check("alt_rvalid", {data_rvalid_o, inst_rvalid_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
         check("alt_rdata", (i % 2 == 0) ? data_rdata_o : inst_rdata_o, 32'hA0 + i);
      end
      inst_req_i = 1'b0; data_req_i = 1'b0;
      tick();
      // fetch timeout
      inst_req_i = 1'b1; inst_addr_i = 32'h300;
      tick();
      check("to_gnt", inst_gnt_o, 1);
      inst_req_i = 1'b0;
      for (int i = 0; i < 254; i++) tick();
      check("to_before", {mem_ce_o, err_o, inst_rvalid_o}, 3'b100);
      tick();
      check("to_err", err_o, 1);
      check("to_rvalid", inst_rvalid_o, 1);
      check("to_rdata", inst_rdata_o, 32'h13);
      check("to_ce", mem_ce_o, 0);
      tick();
      check("to_pulse", {err_o, inst_rvalid_o, mem_ce_o}, 0);
      // ready on the last wait cycle completes normally
      inst_req_i = 1'b1;
      tick();
      inst_req_i = 1'b0;
      for (int i = 0; i < 254; i++) tick();
      mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_CAFE;
      tick();
      mem_ready_i = 1'b0;
      check("edge_err", err_o, 0);
      check("edge_rvalid", inst_rvalid_o, 1);
      check("edge_rdata", inst_rdata_o, 32'h0000_CAFE);
      // reset mid data access
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h500;
      tick();
      check("mid_ce", mem_ce_o, 1);
      data_req_i = 1'b0;
      rst = 1'b1; #1;
      check("mid_async_ce", mem_ce_o, 0);
      check("mid_async_gnt", data_gnt_o, 0);
      tick();
      rst = 1'b0;
      check("mid_no_rvalid", {data_rvalid_o, err_o}, 0);
      inst_req_i = 1'b1; data_req_i = 1'b1;
      tick();
      check("mid_tie_data", {data_gnt_o, inst_gnt_o}, 2'b10);
      check("mid_no_rvalid2", data_rvalid_o, 0);
      inst_req_i = 1'b0; data_req_i = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
